siso_frame_ctrl: RTL and testbench

Controller that sequences a DEPTH-stage serial-in/serial-out shift register. It accepts a WIDTH-bit word over a valid/ready handshake, drives the word bit-serially onto the register's serial input, and flushes the register. It reassembles the bits emerging at the serial output into a WIDTH-bit result with its own valid/ready handshake. It sits between a parallel producer/consumer and the SISO chain, acting as the chain's only driver.

---
 rtl/siso_ctrl_pkg.sv | 20 ++
 rtl/siso_chain.sv | 34 +++
 rtl/siso_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_siso_frame_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/siso_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// siso_ctrl_pkg
// Shared definitions for the SISO frame controller: the controller state
// encoding and the helper that sizes the bit counter.
// -----------------------------------------------------------------------------
package siso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The counter must reach WIDTH+DEPTH without wrapping.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_chain.sv
// -----------------------------------------------------------------------------
// siso_chain
// DEPTH-stage serial-in/serial-out shift register. Each edge with shift_en
// high moves every bit one stage towards S0 and loads Si into the first stage.
//
// Ports:
//   clk       rising-edge clock
//   Si        serial input (first stage)
//   shift_en  advance the chain at this edge
//   S0        serial output (last stage)
// -----------------------------------------------------------------------------
module siso_chain #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic Si,
    input  logic shift_en,
    output logic S0
);

    logic [DEPTH-1:0] stages;

    // NOTE: storage without a reset is deliberate; the controller never reads
    // a stage until DEPTH fresh bits have been pushed through it.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            // Shift-and-or form stays legal for DEPTH == 1.
            stages <= (stages << 1) | DEPTH'(Si);
        end
    end

    assign S0 = stages[DEPTH-1];

endmodule

// File: rtl/siso_frame_ctrl.sv
// -----------------------------------------------------------------------------
// siso_frame_ctrl
// Accepts a WIDTH-bit word, drives it bit-serially into an external DEPTH-stage
// SISO chain, flushes the chain with zeros and reassembles the bits appearing
// at the chain output into out_data.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake, in_data word to serialize
//   Si, shift_en          drive the SISO chain input and advance strobe
//   S0                    serial output of the SISO chain
//   out_valid/out_ready   consumer handshake, out_data reassembled word
//   busy                  high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module siso_frame_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             Si,
    output logic             shift_en,
    input  logic             S0,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH, DEPTH);

    localparam logic [CW-1:0] LAST_TX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_ALL = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] FIRST_RX = CW'(DEPTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] rx_next;
    logic             accept;
    logic             capture;
    int               tx_pos;
    int               rx_pos;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and decoded handshake/strobe outputs.
    // NOTE: every output is given a default first so no path leaves a signal
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST_TX) state_next = DRAIN;
            end
            DRAIN: begin
                shift_en = 1'b1;
                if (cnt == LAST_ALL) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit steering. Cycle c transmits bit position tx_pos(c); the bit seen at
    // S0 in cycle c was transmitted DEPTH cycles earlier, so it lands at the
    // position that cycle c-DEPTH sent from.
    always_comb begin
        tx_pos  = MSB_FIRST ? (WIDTH - 1 - int'(cnt)) : int'(cnt);
        rx_pos  = MSB_FIRST ? (WIDTH - 1 - (int'(cnt) - DEPTH)) : (int'(cnt) - DEPTH);
        capture = shift_en && (cnt >= FIRST_RX);
        Si      = 1'b0;
        rx_next = rx_reg;
        for (int i = 0; i < WIDTH; i++) begin
            if ((state == SHIFT) && (tx_pos == i)) Si = tx_reg[i];
            if (capture && (rx_pos == i)) rx_next[i] = S0;
        end
    end

    // Datapath: word latch, bit counter, receive assembly, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                tx_reg <= in_data;
                cnt    <= '0;
                rx_reg <= '0;
            end else if (shift_en) begin
                cnt    <= cnt + CW'(1);
                rx_reg <= rx_next;
            end

            // The final capture happens on the same edge that enters DONE, so
            // the published word takes the freshly assembled value.
            if (shift_en && (cnt == LAST_ALL)) begin
                out_valid <= 1'b1;
                out_data  <= rx_next;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_frame_ctrl
// Two controllers (MSB-first and LSB-first), each closing the loop through its
// own siso_chain. The expected serial stream and result of every word are
// derived from the word itself; out_data must equal the accepted word.
// -----------------------------------------------------------------------------
module tb_siso_frame_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = W + D;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic         in_valid  [2];
    logic [W-1:0] in_data   [2];
    logic         out_ready [2];
    logic         in_ready  [2];
    logic         si        [2];
    logic         shift_en  [2];
    logic         s0        [2];
    logic         out_valid [2];
    logic [W-1:0] out_data  [2];
    logic         busy      [2];

    int checks = 0;
    int errors = 0;

    siso_frame_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .Si(si[0]), .shift_en(shift_en[0]), .S0(s0[0]),
        .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
        .busy(busy[0])
    );
    siso_chain #(.DEPTH(D)) chain0 (.clk(clk), .Si(si[0]), .shift_en(shift_en[0]), .S0(s0[0]));

    siso_frame_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .Si(si[1]), .shift_en(shift_en[1]), .S0(s0[1]),
        .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
        .busy(busy[1])
    );
    siso_chain #(.DEPTH(D)) chain1 (.clk(clk), .Si(si[1]), .shift_en(shift_en[1]), .S0(s0[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference stream: WIDTH data bits in transmit order, then DEPTH zeros.
    function automatic logic exp_si(input logic [W-1:0] w, input bit msb, input int k);
        logic [W-1:0] sh;
        if (k >= W) return 1'b0;
        sh = msb ? (w >> (W - 1 - k)) : (w >> k);
        return sh[0];
    endfunction

    // One complete transaction on controller u. hold = cycles spent in DONE
    // with out_ready low; noise: 0 quiet, 1 random in_valid/in_data while busy,
    // 2 in_valid high with all-ones data while busy.
    task automatic run_word(input int u, input logic [W-1:0] w, input int hold, input int noise);
        bit msb;
        msb = (u == 0);
        chk("idle_in_ready", 32'(in_ready[u]), 32'd1);
        in_valid[u]  = 1'b1;
        in_data[u]   = w;
        out_ready[u] = (hold == 0);
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_data[u]  = '0;
        for (int k = 0; k < N; k++) begin
            if (noise == 1) begin
                in_valid[u] = 1'($urandom);
                in_data[u]  = W'($urandom);
            end else if (noise == 2) begin
                in_valid[u] = 1'b1;
                in_data[u]  = 8'hFF;
            end
            chk($sformatf("shift_en_c%0d", k), 32'(shift_en[u]), 32'd1);
            chk($sformatf("si_c%0d", k), 32'(si[u]), 32'(exp_si(w, msb, k)));
            chk("busy_in_ready", 32'(in_ready[u]), 32'd0);
            chk("busy_flag", 32'(busy[u]), 32'd1);
            chk("early_out_valid", 32'(out_valid[u]), 32'd0);
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
        chk("done_out_valid", 32'(out_valid[u]), 32'd1);
        chk("done_out_data", 32'(out_data[u]), 32'(w));
        chk("done_shift_en", 32'(shift_en[u]), 32'd0);
        chk("done_in_ready", 32'(in_ready[u]), 32'd0);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid[u]), 32'd1);
            chk("hold_out_data", 32'(out_data[u]), 32'(w));
            chk("hold_in_ready", 32'(in_ready[u]), 32'd0);
        end
        out_ready[u] = 1'b1;
        @(negedge clk);
        chk("post_in_ready", 32'(in_ready[u]), 32'd1);
        chk("post_out_valid", 32'(out_valid[u]), 32'd0);
        chk("post_busy", 32'(busy[u]), 32'd0);
        chk("post_shift_en", 32'(shift_en[u]), 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = '0;
            out_ready[u] = 1'b1;
        end

        // Reset held for two edges; in_valid during reset must not be taken.
        rst = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h77;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_in_ready", 32'(in_ready[u]), 32'd1);
            chk("rst_busy", 32'(busy[u]), 32'd0);
            chk("rst_shift_en", 32'(shift_en[u]), 32'd0);
            chk("rst_si", 32'(si[u]), 32'd0);
            chk("rst_out_valid", 32'(out_valid[u]), 32'd0);
            chk("rst_out_data", 32'(out_data[u]), 32'd0);
        end
        in_valid[0] = 1'b0;
        in_data[0]  = '0;
        rst = 1'b0;
        @(negedge clk);

        // Directed words.
        run_word(0, 8'hA5, 0, 0);
        run_word(1, 8'h01, 0, 0);
        run_word(0, 8'h3C, 5, 0);
        run_word(0, 8'h5A, 0, 2);

        // Reset during SHIFT cycle 3 aborts the word.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h96;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_shift_en", 32'(shift_en[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort_shift_en", 32'(shift_en[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_out_data", 32'(out_data[0]), 32'd0);
        for (int i = 0; i < N + 4; i++) begin
            chk("abort_no_out_valid", 32'(out_valid[0]), 32'd0);
            chk("abort_idle_shift_en", 32'(shift_en[0]), 32'd0);
            @(negedge clk);
        end
        run_word(0, 8'hC3, 0, 0);

        // Randomized words, hold times, busy-time noise and idle gaps.
        for (int i = 0; i < 26; i++) begin
            int u;
            u = (i % 4 == 3) ? 1 : 0;
            run_word(u, W'($urandom), int'($urandom_range(0, 3)), 1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("gap_idle", 32'(in_ready[u]), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
